// File: rtl/config_mux_pkg.sv
// rtl/config_mux_pkg.sv - opcodes, header field positions and FSM states for config_mux
package config_mux_pkg;

  // Header opcodes received from the host
  localparam logic [3:0] OPC_WRITE  = 4'h1;
  localparam logic [3:0] OPC_READ   = 4'h2;
  // Opcodes of words pushed back to the host
  localparam logic [3:0] OPC_ACK    = 4'h9;
  localparam logic [3:0] OPC_RDRESP = 4'hA;

  // Header word layout: {opcode, count, start address}
  localparam int HDR_OPC_MSB = 31;
  localparam int HDR_OPC_LSB = 28;
  localparam int HDR_CNT_MSB = 27;
  localparam int HDR_CNT_LSB = 16;
  localparam int HDR_ADR_MSB = 15;
  localparam int HDR_ADR_LSB = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_DATA,
    ST_WR_ACK,
    ST_RD_HDR,
    ST_RD_ISSUE,
    ST_RD_WAIT,
    ST_RD_PUSH
  } state_e;

endpackage

// File: rtl/config_mux_if.sv
// rtl/config_mux_if.sv - payload stream, TX FIFO and register bus bundle for config_mux
interface config_mux_if;
  logic        rx_ready;
  logic [31:0] rx_data;
  logic        tx_full;
  logic        tx_wr;
  logic [31:0] tx_data;
  logic [15:0] address;
  logic        wr;
  logic        rd;
  logic [31:0] dout;
  logic [31:0] din;
  logic        busy;
  logic        overrun;
  logic [7:0]  illegal_cnt;

  // master: the command decoder itself
  modport master (
    input  rx_ready, rx_data, tx_full, din,
    output tx_wr, tx_data, address, wr, rd, dout, busy, overrun, illegal_cnt
  );

  // slave: receiver, TX FIFO and register space around the decoder
  modport slave (
    output rx_ready, rx_data, tx_full, din,
    input  tx_wr, tx_data, address, wr, rd, dout, busy, overrun, illegal_cnt
  );
endinterface

// File: rtl/config_mux.sv
// rtl/config_mux.sv - decodes payload write/read commands onto the register bus and answers via TX FIFO
module config_mux
  import config_mux_pkg::*;
#(
  parameter int RD_LATENCY = 2
) (
  input  logic         clk,
  input  logic         reset,
  config_mux_if.master bus
);

  localparam logic [3:0] LAT_LAST = 4'(RD_LATENCY - 1);

  state_e      state_q, state_d;
  logic [15:0] address_q, address_d;
  logic [11:0] remaining_q, remaining_d;
  logic [31:0] dout_q, dout_d;
  logic        wr_q, wr_d;
  logic [31:0] tx_data_q, tx_data_d;
  logic [3:0]  lat_q, lat_d;
  logic        overrun_q, overrun_d;
  logic [7:0]  illegal_q, illegal_d;
  logic        tx_wr;
  logic        rd;

  logic [3:0]  hdr_opc;
  logic [11:0] hdr_cnt;
  logic [15:0] hdr_adr;
  logic        hdr_ok;

  assign hdr_opc = bus.rx_data[HDR_OPC_MSB:HDR_OPC_LSB];
  assign hdr_cnt = bus.rx_data[HDR_CNT_MSB:HDR_CNT_LSB];
  assign hdr_adr = bus.rx_data[HDR_ADR_MSB:HDR_ADR_LSB];
  assign hdr_ok  = ((hdr_opc == OPC_WRITE) || (hdr_opc == OPC_READ)) && (hdr_cnt != 12'd0);

  // Next-state, datapath updates and the two combinational strobes
  always_comb begin
    state_d     = state_q;
    address_d   = address_q;
    remaining_d = remaining_q;
    dout_d      = dout_q;
    wr_d        = 1'b0;
    tx_data_d   = tx_data_q;
    lat_d       = lat_q;
    overrun_d   = overrun_q;
    illegal_d   = illegal_q;
    tx_wr       = 1'b0;
    rd          = 1'b0;

    // A write is presented one cycle after its word; step past it once it is on the bus
    if (wr_q) begin
      address_d = address_q + 16'd1;
    end

    case (state_q)
      ST_IDLE: begin
        if (bus.rx_ready) begin
          if (hdr_ok) begin
            address_d   = hdr_adr;
            remaining_d = hdr_cnt;
            // Preload the header echo so tx_data is already stable when the push is attempted
            if (hdr_opc == OPC_WRITE) begin
              state_d   = ST_WR_DATA;
              tx_data_d = {OPC_ACK, hdr_cnt, hdr_adr};
            end else begin
              state_d   = ST_RD_HDR;
              tx_data_d = {OPC_RDRESP, hdr_cnt, hdr_adr};
            end
          end else if (illegal_q != 8'hFF) begin
            illegal_d = illegal_q + 8'd1;
          end
        end
      end
      ST_WR_DATA: begin
        if (bus.rx_ready) begin
          wr_d        = 1'b1;
          dout_d      = bus.rx_data;
          remaining_d = remaining_q - 12'd1;
          if (remaining_q == 12'd1) begin
            state_d = ST_WR_ACK;
          end
        end
      end
      ST_WR_ACK: begin
        if (!bus.tx_full) begin
          tx_wr   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_RD_HDR: begin
        if (!bus.tx_full) begin
          tx_wr   = 1'b1;
          state_d = ST_RD_ISSUE;
        end
      end
      ST_RD_ISSUE: begin
        rd      = 1'b1;
        lat_d   = 4'd0;
        state_d = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        if (lat_q == LAT_LAST) begin
          tx_data_d = bus.din;
          state_d   = ST_RD_PUSH;
        end else begin
          lat_d = lat_q + 4'd1;
        end
      end
      ST_RD_PUSH: begin
        if (!bus.tx_full) begin
          tx_wr       = 1'b1;
          address_d   = address_q + 16'd1;
          remaining_d = remaining_q - 12'd1;
          state_d     = (remaining_q == 12'd1) ? ST_IDLE : ST_RD_ISSUE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Only IDLE and WR_DATA can take a word; anything else is lost and flagged
    if (bus.rx_ready && (state_q != ST_IDLE) && (state_q != ST_WR_DATA)) begin
      overrun_d = 1'b1;
    end
  end

  // State and datapath registers; reset abandons any command in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      address_q   <= 16'd0;
      remaining_q <= 12'd0;
      dout_q      <= 32'd0;
      wr_q        <= 1'b0;
      tx_data_q   <= 32'd0;
      lat_q       <= 4'd0;
      overrun_q   <= 1'b0;
      illegal_q   <= 8'd0;
    end else begin
      state_q     <= state_d;
      address_q   <= address_d;
      remaining_q <= remaining_d;
      dout_q      <= dout_d;
      wr_q        <= wr_d;
      tx_data_q   <= tx_data_d;
      lat_q       <= lat_d;
      overrun_q   <= overrun_d;
      illegal_q   <= illegal_d;
    end
  end

  assign bus.tx_wr       = tx_wr;
  assign bus.tx_data     = tx_data_q;
  assign bus.address     = address_q;
  assign bus.wr          = wr_q;
  assign bus.rd          = rd;
  assign bus.dout        = dout_q;
  assign bus.busy        = (state_q != ST_IDLE);
  assign bus.overrun     = overrun_q;
  assign bus.illegal_cnt = illegal_q;

endmodule

// File: tb/tb_config_mux.sv
// tb/tb_config_mux.sv - directed self-checking bench for config_mux
module tb_config_mux;
  localparam int RDL = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  config_mux_if bus_if ();

  config_mux #(.RD_LATENCY(RDL)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_if.master)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Event logs captured mid-cycle
  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  logic [31:0] tx_q[$];
  logic [31:0] rd_addr_q[$];
  int          wr_cyc_q[$];
  int          tx_cyc_q[$];
  int          rd_cyc_q[$];

  always @(negedge clk) begin
    if (!reset) begin
      if (bus_if.wr) begin
        wr_addr_q.push_back({16'h0, bus_if.address});
        wr_data_q.push_back(bus_if.dout);
        wr_cyc_q.push_back(cyc);
      end
      if (bus_if.tx_wr) begin
        tx_q.push_back(bus_if.tx_data);
        tx_cyc_q.push_back(cyc);
      end
      if (bus_if.rd) begin
        rd_addr_q.push_back({16'h0, bus_if.address});
        rd_cyc_q.push_back(cyc);
      end
    end
  end

  // Register space: returns address*3 only in the cycle RDL after rd, garbage otherwise
  logic        sr_v[RDL+1];
  logic [31:0] sr_d[RDL+1];
  always @(negedge clk) begin
    sr_v[0] <= bus_if.rd;
    sr_d[0] <= {16'h0, bus_if.address} * 32'd3;
    for (int i = 1; i <= RDL; i++) begin
      sr_v[i] <= sr_v[i-1];
      sr_d[i] <= sr_d[i-1];
    end
  end
  assign bus_if.din = sr_v[RDL] ? sr_d[RDL] : 32'hBAD0_BAD0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic send_word(input logic [31:0] w, output int c);
    bus_if.rx_ready = 1'b1;
    bus_if.rx_data  = w;
    c = cyc;
    step();
    bus_if.rx_ready = 1'b0;
    bus_if.rx_data  = 32'h0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (bus_if.busy && n < budget) begin
      step();
      n++;
    end
    check_eq(tag, 32'(bus_if.busy), 32'd0);
  endtask

  task automatic clear_logs();
    wr_addr_q.delete(); wr_data_q.delete(); wr_cyc_q.delete();
    tx_q.delete(); tx_cyc_q.delete();
    rd_addr_q.delete(); rd_cyc_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int h, c, t, hold_err;
    bus_if.rx_ready = 1'b0;
    bus_if.rx_data  = 32'h0;
    bus_if.tx_full  = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Reset values
    check_eq("rst_tx_wr",   32'(bus_if.tx_wr), 32'd0);
    check_eq("rst_tx_data", bus_if.tx_data, 32'd0);
    check_eq("rst_address", 32'(bus_if.address), 32'd0);
    check_eq("rst_wr",      32'(bus_if.wr), 32'd0);
    check_eq("rst_rd",      32'(bus_if.rd), 32'd0);
    check_eq("rst_dout",    bus_if.dout, 32'd0);
    check_eq("rst_busy",    32'(bus_if.busy), 32'd0);
    check_eq("rst_overrun", 32'(bus_if.overrun), 32'd0);
    check_eq("rst_illegal", 32'(bus_if.illegal_cnt), 32'd0);
    reset = 1'b0;
    step();

    // WRITE of two words at 0x0010
    clear_logs();
    send_word(32'h1002_0010, h);
    send_word(32'hDEAD_BEEF, c);
    send_word(32'h1234_5678, t);
    wait_idle("wr_idle", 50);
    step();
    check_eq("wr_count",   32'(wr_addr_q.size()), 32'd2);
    check_eq("wr0_addr",   wr_addr_q[0], 32'h0010);
    check_eq("wr0_data",   wr_data_q[0], 32'hDEAD_BEEF);
    check_eq("wr0_cycle",  32'(wr_cyc_q[0]), 32'(c + 1));
    check_eq("wr1_addr",   wr_addr_q[1], 32'h0011);
    check_eq("wr1_data",   wr_data_q[1], 32'h1234_5678);
    check_eq("wr_tx_cnt",  32'(tx_q.size()), 32'd1);
    check_eq("wr_ack",     tx_q[0], 32'h9002_0010);
    check_eq("wr_ack_cyc", 32'(tx_cyc_q[0]), 32'(t + 1));
    check_eq("wr_rd_none", 32'(rd_cyc_q.size()), 32'd0);

    // READ of three words wrapping past 0xFFFF
    clear_logs();
    send_word(32'h2003_FFFE, h);
    wait_idle("rd_idle", 100);
    step();
    check_eq("rd_tx_cnt",  32'(tx_q.size()), 32'd4);
    check_eq("rd_hdr",     tx_q[0], 32'hA003_FFFE);
    check_eq("rd_hdr_cyc", 32'(tx_cyc_q[0]), 32'(h + 1));
    check_eq("rd_d0",      tx_q[1], 32'h0002_FFFA);
    check_eq("rd_d0_cyc",  32'(tx_cyc_q[1]), 32'(h + 3 + RDL));
    check_eq("rd_d1",      tx_q[2], 32'h0002_FFFD);
    check_eq("rd_d2_wrap", tx_q[3], 32'h0000_0000);
    check_eq("rd_rd_cnt",  32'(rd_cyc_q.size()), 32'd3);
    check_eq("rd_rd0_cyc", 32'(rd_cyc_q[0]), 32'(h + 2));
    check_eq("rd_rd_gap1", 32'(rd_cyc_q[1] - rd_cyc_q[0]), 32'(RDL + 2));
    check_eq("rd_rd_gap2", 32'(rd_cyc_q[2] - rd_cyc_q[1]), 32'(RDL + 2));
    check_eq("rd_rd2_adr", rd_addr_q[2], 32'h0000);

    // READ N=2 with TX FIFO full across the first data push
    clear_logs();
    send_word(32'h2002_0100, h);
    step(); step(); step();
    bus_if.tx_full = 1'b1;
    hold_err = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus_if.tx_wr !== 1'b0) hold_err++;
      if (bus_if.tx_data !== 32'h0000_0300) hold_err++;
    end
    check_eq("full_hold_err", 32'(hold_err), 32'd0);
    check_eq("full_busy",     32'(bus_if.busy), 32'd1);
    check_eq("full_rd_cnt",   32'(rd_cyc_q.size()), 32'd1);
    bus_if.tx_full = 1'b0;
    wait_idle("full_idle", 100);
    step();
    check_eq("full_rd_total", 32'(rd_cyc_q.size()), 32'd2);
    check_eq("full_tx_cnt",   32'(tx_q.size()), 32'd3);
    check_eq("full_hdr",      tx_q[0], 32'hA002_0100);
    check_eq("full_d0",       tx_q[1], 32'h0000_0300);
    check_eq("full_d1",       tx_q[2], 32'h0000_0303);

    // Illegal headers and saturation
    clear_logs();
    send_word(32'h3001_0000, c);
    send_word(32'h1000_0000, c);
    step(); step(); step();
    check_eq("ill_cnt2",    32'(bus_if.illegal_cnt), 32'd2);
    check_eq("ill_no_wr",   32'(wr_cyc_q.size()), 32'd0);
    check_eq("ill_no_tx",   32'(tx_cyc_q.size()), 32'd0);
    check_eq("ill_no_rd",   32'(rd_cyc_q.size()), 32'd0);
    check_eq("ill_busy",    32'(bus_if.busy), 32'd0);
    check_eq("ill_overrun", 32'(bus_if.overrun), 32'd0);
    for (int i = 0; i < 298; i++) send_word(32'h3001_0000, c);
    step();
    check_eq("ill_sat", 32'(bus_if.illegal_cnt), 32'd255);

    // Word arriving during RD_WAIT is dropped and flagged
    clear_logs();
    send_word(32'h2001_0020, h);
    step(); step();
    send_word(32'h1001_0050, c);
    check_eq("ovr_set", 32'(bus_if.overrun), 32'd1);
    wait_idle("ovr_idle", 100);
    repeat (10) step();
    check_eq("ovr_tx_cnt", 32'(tx_q.size()), 32'd2);
    check_eq("ovr_hdr",    tx_q[0], 32'hA001_0020);
    check_eq("ovr_data",   tx_q[1], 32'h0000_0060);
    check_eq("ovr_no_wr",  32'(wr_cyc_q.size()), 32'd0);
    check_eq("ovr_sticky", 32'(bus_if.overrun), 32'd1);

    // Reset in the middle of a WRITE
    clear_logs();
    send_word(32'h1003_0040, h);
    send_word(32'hAAAA_0001, c);
    check_eq("mid_wr_pulse", 32'(bus_if.wr), 32'd1);
    reset = 1'b1;
    #1;
    check_eq("mid_wr",      32'(bus_if.wr), 32'd0);
    check_eq("mid_address", 32'(bus_if.address), 32'd0);
    check_eq("mid_dout",    bus_if.dout, 32'd0);
    check_eq("mid_busy",    32'(bus_if.busy), 32'd0);
    check_eq("mid_overrun", 32'(bus_if.overrun), 32'd0);
    check_eq("mid_illegal", 32'(bus_if.illegal_cnt), 32'd0);
    step(); step();
    reset = 1'b0;
    repeat (5) step();
    check_eq("mid_no_ack", 32'(tx_q.size()), 32'd0);
    send_word(32'h2001_0005, h);
    wait_idle("mid_rd_idle", 100);
    step();
    check_eq("mid_rd_cnt",  32'(tx_q.size()), 32'd2);
    check_eq("mid_rd_hdr",  tx_q[0], 32'hA001_0005);
    check_eq("mid_rd_data", tx_q[1], 32'h0000_000F);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
